// File: rtl/cdb_arb_if.sv
// Bundle of function-unit result ports and common-data-bus lanes used by cdb_arbiter.
// The arbiter takes the slave modport; the FU side and the CDB consumers drive the master modport.
`ifndef NUM_OF_FU
`define NUM_OF_FU 4
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

interface cdb_arb_if #(
  parameter int NUM_FU    = `NUM_OF_FU,
  parameter int CDB_LANES = 2,
  parameter int AW        = `PHYSICAL_REG_NUM_WIDTH,
  parameter int VW        = `REG_VAL_WIDTH,
  parameter int TW        = `ROB_SIZE_WIDTH,
  parameter int SW        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
);
  logic [NUM_FU-1:0]    fu_valid;
  logic [NUM_FU-1:0]    fu_ready;
  logic [AW-1:0]        fu_reg_addr [NUM_FU];
  logic [VW-1:0]        fu_reg_val  [NUM_FU];
  logic [TW-1:0]        fu_tag      [NUM_FU];

  logic                 cdb_ready;
  logic [CDB_LANES-1:0] cdb_valid;
  logic [AW-1:0]        cdb_reg_addr [CDB_LANES];
  logic [VW-1:0]        cdb_reg_val  [CDB_LANES];
  logic [TW-1:0]        cdb_tag      [CDB_LANES];
  logic [SW-1:0]        cdb_src      [CDB_LANES];

  modport master (
    output fu_valid, fu_reg_addr, fu_reg_val, fu_tag, cdb_ready,
    input  fu_ready, cdb_valid, cdb_reg_addr, cdb_reg_val, cdb_tag, cdb_src
  );

  modport slave (
    input  fu_valid, fu_reg_addr, fu_reg_val, fu_tag, cdb_ready,
    output fu_ready, cdb_valid, cdb_reg_addr, cdb_reg_val, cdb_tag, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter moving per-FU FIFO heads onto CDB_LANES registered common-data-bus lanes.
// Define CDB_ARB_BYPASS_EN to let an FU with an empty FIFO compete with its live input (1-edge latency).
`ifndef NUM_OF_FU
`define NUM_OF_FU 4
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

module cdb_arbiter #(
  parameter int NUM_FU     = `NUM_OF_FU,
  parameter int CDB_LANES  = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  cdb_arb_if.slave bus
);
  localparam int AW = `PHYSICAL_REG_NUM_WIDTH;
  localparam int VW = `REG_VAL_WIDTH;
  localparam int TW = `ROB_SIZE_WIDTH;
  localparam int SW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] reg_addr;
    logic [VW-1:0] reg_val;
    logic [TW-1:0] tag;
  } result_t;

  typedef struct packed {
    logic          valid;
    logic [SW-1:0] src;
    result_t       res;
  } lane_t;

  result_t       mem    [NUM_FU][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr [NUM_FU];
  logic [PW-1:0] wr_ptr [NUM_FU];
  logic [CW-1:0] count  [NUM_FU];
  logic [SW-1:0] rr_ptr, rr_nxt;
  lane_t         lane_q [CDB_LANES];
  lane_t         lane_d [CDB_LANES];
  result_t       fu_res [NUM_FU];
  logic [NUM_FU-1:0] ready, push, pop, bypass;
  logic          any_lane_valid, load;

  // Ready depends only on registered occupancy, never on cdb_ready or fu_valid.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_res[i] = '{reg_addr: bus.fu_reg_addr[i], reg_val: bus.fu_reg_val[i], tag: bus.fu_tag[i]};
      ready[i]  = (count[i] < CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    any_lane_valid = 1'b0;
    for (int l = 0; l < CDB_LANES; l++) any_lane_valid |= lane_q[l].valid;
  end

  assign load = !any_lane_valid || bus.cdb_ready;

  // Scan from rr_ptr with wrap; the first CDB_LANES requesters fill lanes in scan order.
  always_comb begin
    int n;
    int idx;
    int last;
    // NOTE: every output of this block gets a default before any branch, so no latch can be inferred.
    n      = 0;
    idx    = 0;
    last   = 0;
    pop    = '0;
    bypass = '0;
    rr_nxt = rr_ptr;
    for (int l = 0; l < CDB_LANES; l++) lane_d[l] = '0;
    if (load) begin
      for (int k = 0; k < NUM_FU; k++) begin
        // NOTE: blocking assignments here are deliberate; n and idx are scratch values reused within one scan.
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (n < CDB_LANES) begin
          if (count[idx] != '0) begin
            lane_d[n] = '{valid: 1'b1, src: SW'(idx), res: mem[idx][rd_ptr[idx]]};
            pop[idx]  = 1'b1;
            last      = idx;
            n         = n + 1;
          end
`ifdef CDB_ARB_BYPASS_EN
          else if (bus.fu_valid[idx]) begin
            lane_d[n]   = '{valid: 1'b1, src: SW'(idx), res: fu_res[idx]};
            bypass[idx] = 1'b1;
            last        = idx;
            n           = n + 1;
          end
`endif
        end
      end
      if (n > 0) rr_nxt = (last == NUM_FU - 1) ? '0 : SW'(last + 1);
    end
  end

  assign push = bus.fu_valid & ready & ~bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      for (int l = 0; l < CDB_LANES; l++) lane_q[l] <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      for (int l = 0; l < CDB_LANES; l++) lane_q[l] <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (load) begin
        for (int l = 0; l < CDB_LANES; l++) lane_q[l] <= lane_d[l];
        rr_ptr <= rr_nxt;
      end
    end
  end

  // NOTE: FIFO storage is intentionally not reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i] && !flush) mem[i][wr_ptr[i]] <= fu_res[i];
    end
  end

  assign bus.fu_ready = ready;

  for (genvar l = 0; l < CDB_LANES; l++) begin : g_lane
    assign bus.cdb_valid[l]    = lane_q[l].valid;
    assign bus.cdb_src[l]      = lane_q[l].src;
    assign bus.cdb_reg_addr[l] = lane_q[l].res.reg_addr;
    assign bus.cdb_reg_val[l]  = lane_q[l].res.reg_val;
    assign bus.cdb_tag[l]      = lane_q[l].res.tag;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

module tb_cdb_arbiter;
  localparam int NF    = 4;
  localparam int NL    = 2;
  localparam int DEPTH = 2;
  localparam int AW    = `PHYSICAL_REG_NUM_WIDTH;
  localparam int VW    = `REG_VAL_WIDTH;
  localparam int TW    = `ROB_SIZE_WIDTH;
  localparam int SW    = 2;
`ifdef CDB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [VW-1:0] v;
    logic [TW-1:0] t;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  cdb_arb_if #(.NUM_FU(NF), .CDB_LANES(NL), .AW(AW), .VW(VW), .TW(TW), .SW(SW)) bus ();

  cdb_arbiter #(.NUM_FU(NF), .CDB_LANES(NL), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per FU, the round-robin start index, and the lane contents.
  res_t mq [NF][$];
  int   m_rr;
  bit   m_v [NL];
  res_t m_r [NL];
  int   m_s [NL];

  task automatic model_clear();
    for (int i = 0; i < NF; i++) mq[i].delete();
    m_rr = 0;
    for (int l = 0; l < NL; l++) begin
      m_v[l] = 1'b0;
      m_r[l] = '0;
      m_s[l] = 0;
    end
  endtask

  function automatic res_t fu_in(input int i);
    res_t r;
    r.a = bus.fu_reg_addr[i];
    r.v = bus.fu_reg_val[i];
    r.t = bus.fu_tag[i];
    return r;
  endfunction

  task automatic model_step();
    bit rdy [NF];
    bit byp [NF];
    bit busy;
    int n;
    int last;
    int idx;
    if (flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < NF; i++) begin
      rdy[i] = mq[i].size() < DEPTH;
      byp[i] = 1'b0;
    end
    busy = 1'b0;
    for (int l = 0; l < NL; l++) busy |= m_v[l];
    if (!busy || bus.cdb_ready) begin
      for (int l = 0; l < NL; l++) begin
        m_v[l] = 1'b0;
        m_r[l] = '0;
        m_s[l] = 0;
      end
      n = 0;
      last = 0;
      for (int k = 0; k < NF; k++) begin
        idx = (m_rr + k) % NF;
        if (n < NL) begin
          if (mq[idx].size() > 0) begin
            m_r[n] = mq[idx].pop_front();
            m_v[n] = 1'b1;
            m_s[n] = idx;
            last = idx;
            n++;
          end else if (BYPASS && bus.fu_valid[idx]) begin
            m_r[n] = fu_in(idx);
            m_v[n] = 1'b1;
            m_s[n] = idx;
            byp[idx] = 1'b1;
            last = idx;
            n++;
          end
        end
      end
      if (n > 0) m_rr = (last + 1) % NF;
    end
    for (int i = 0; i < NF; i++)
      if (bus.fu_valid[i] && rdy[i] && !byp[i]) mq[i].push_back(fu_in(i));
  endtask

  task automatic compare();
    logic [NF-1:0] exp_rdy;
    for (int l = 0; l < NL; l++) begin
      check("lane_valid", bus.cdb_valid[l], m_v[l]);
      check("lane_payload", {bus.cdb_src[l], bus.cdb_reg_addr[l], bus.cdb_reg_val[l], bus.cdb_tag[l]},
            {SW'(m_s[l]), m_r[l]});
    end
    for (int i = 0; i < NF; i++) exp_rdy[i] = mq[i].size() < DEPTH;
    check("fu_ready", bus.fu_ready, exp_rdy);
  endtask

  // One clock: model consumes the same inputs the DUT samples, then outputs are compared 1ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive_fu(input int i, input bit v, input logic [TW-1:0] t);
    bus.fu_valid[i]    = v;
    bus.fu_tag[i]      = t;
    bus.fu_reg_addr[i] = AW'($urandom);
    bus.fu_reg_val[i]  = VW'($urandom);
  endtask

  task automatic idle();
    for (int i = 0; i < NF; i++) drive_fu(i, 1'b0, '0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    idle();
    step();
    flush = 1'b0;
  endtask

  // Present one pulse from the FUs in mask, then count edges until lane 0 shows a result.
  task automatic pulse_wait(input logic [NF-1:0] mask, input int t0, output int lat);
    for (int i = 0; i < NF; i++) drive_fu(i, mask[i], TW'(t0 + i));
    step();
    lat = 1;
    idle();
    while (!bus.cdb_valid[0] && lat < 6) begin
      step();
      lat++;
    end
    if (!bus.cdb_valid[0]) begin
      n_checks++;
      n_fail++;
      $display("FAIL lane0_timeout: no grant after %0d edges, expected one", lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_src;
    int lane_cnt;
    bit seen;

    reset = 1'b1;
    flush = 1'b0;
    bus.cdb_ready = 1'b1;
    idle();
    model_clear();
    #12;
    check("reset_cdb_valid", bus.cdb_valid, '0);
    check("reset_fu_ready", bus.fu_ready, 4'hf);
    check("reset_src0", bus.cdb_src[0], '0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin with every FU requesting: lane pairs alternate {0,1},{2,3}.
    seen = 1'b0;
    exp_src = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NF; i++) drive_fu(i, 1'b1, TW'(i * 8 + c % 8));
      step();
      if (bus.cdb_valid[0]) begin
        if (!seen) check("rr_first_tag", bus.cdb_tag[0], '0);
        seen = 1'b1;
        check("rr_lane0_src", bus.cdb_src[0], exp_src);
        check("rr_lane1_src", bus.cdb_src[1], exp_src + 1);
        exp_src ^= 2;
      end
    end
    idle();
    repeat (8) step();

    // Stall: tags 5/9 held on the lanes while FIFOs fill behind them.
    do_flush();
    drive_fu(0, 1'b1, TW'(5));
    drive_fu(1, 1'b1, TW'(9));
    step();
    bus.cdb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NF; i++) drive_fu(i, 1'b1, TW'(16 + 4 * c + i));
      step();
      if (c > 0) begin
        check("stall_lane0_tag", {bus.cdb_valid[0], bus.cdb_tag[0]}, {1'b1, TW'(5)});
        check("stall_lane1_tag", {bus.cdb_valid[1], bus.cdb_tag[1]}, {1'b1, TW'(9)});
      end
    end
    check("stall_fu_ready_low", bus.fu_ready, 4'h0);
    idle();
    bus.cdb_ready = 1'b1;
    lane_cnt = 0;
    repeat (8) begin
      step();
      for (int l = 0; l < NL; l++) lane_cnt += int'(bus.cdb_valid[l]);
    end
    check("stall_release_count", lane_cnt, 8);

    // Single requester wrap: FU 2 moves rr_ptr to 3, FU 3 then wraps it to 0.
    do_flush();
    pulse_wait(4'b0100, 1, lat);
    check("wrap_fu2_src", bus.cdb_src[0], 2);
    pulse_wait(4'b1000, 1, lat);
    check("wrap_fu3_src", bus.cdb_src[0], 3);
    pulse_wait(4'b1001, 10, lat);
    check("wrap_next_lane0", {bus.cdb_src[0], bus.cdb_tag[0]}, {SW'(0), TW'(10)});
    check("wrap_next_lane1", {bus.cdb_src[1], bus.cdb_tag[1]}, {SW'(3), TW'(13)});
    idle();
    repeat (3) step();

    // Bypass latency: FU 1 tag 7 into an empty arbiter.
    do_flush();
    pulse_wait(4'b0010, 6, lat);
    check("bypass_latency", lat, BYPASS ? 1 : 2);
    check("bypass_lane0", {bus.cdb_src[0], bus.cdb_tag[0]}, {SW'(1), TW'(7)});
    idle();
    repeat (3) step();

    // Flush with full FIFOs and valid lanes; FU 3 pushes tag 31 in the flush cycle.
    bus.cdb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 3; i++) drive_fu(i, 1'b1, TW'(c * 3 + i));
      step();
    end
    idle();
    drive_fu(3, 1'b1, TW'(31));
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("flush_cdb_valid", bus.cdb_valid, '0);
    check("flush_fu_ready", bus.fu_ready, 4'hf);
    check("flush_lane0", {bus.cdb_src[0], bus.cdb_tag[0], bus.cdb_reg_val[0]}, '0);
    bus.cdb_ready = 1'b1;
    repeat (4) begin
      step();
      check("flush_no_ghost", bus.cdb_valid, '0);
    end

    // Reset between edges with three FIFOs holding data.
    bus.cdb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) drive_fu(i, 1'b1, TW'(20 + c * 3 + i));
      step();
    end
    idle();
    #3;
    reset = 1'b1;
    #1;
    check("midreset_cdb_valid", bus.cdb_valid, '0);
    check("midreset_fu_ready", bus.fu_ready, 4'hf);
    check("midreset_src", {bus.cdb_src[0], bus.cdb_src[1]}, '0);
    model_clear();
    #1;
    reset = 1'b0;
    bus.cdb_ready = 1'b1;
    pulse_wait(4'b1101, 0, lat);
    check("midreset_next_grant", {bus.cdb_src[0], bus.cdb_src[1]}, {SW'(0), SW'(2)});
    idle();
    repeat (3) step();

    // Randomized traffic with back-pressure and occasional flush.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NF; i++) drive_fu(i, $urandom_range(0, 99) < 60, TW'($urandom));
      bus.cdb_ready = $urandom_range(0, 99) < 75;
      flush = $urandom_range(0, 199) == 0;
      step();
    end
    flush = 1'b0;
    idle();
    bus.cdb_ready = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
